spi_slave_frame: RTL and testbench

//   Synthesizable SPI slave, downstream peer of the SPI master model: receives CRC-8 protected frames, returns its own frame on miso.
//   SPI mode 0, MSB first; frame = DATA_BYTES payload bytes + 1 CRC byte; sclk/cs_b/mosi oversampled on clk.

---
 rtl/spi_slave_frame.sv | 196 +++++++++++++++++++
 tb/tb_spi_slave_frame.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_frame.sv
// SPI mode-0 slave exchanging CRC-8 protected frames (DATA_BYTES payload + 1 CRC byte), inputs oversampled on clk.
// Optional SPI_SLAVE_MISO_TRISTATE_EN: release miso (1'bz) while the synchronized chip select is high.
module spi_slave_frame #(
  parameter int         DATA_BYTES  = 7,
  parameter logic [7:0] CRC_POLY    = 8'h2F,
  parameter logic [7:0] CRC_SEED    = 8'hFF,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cs_b,
  input  logic                    sclk,
  input  logic                    mosi,
  output logic                    miso,
  input  logic [8*DATA_BYTES-1:0] tx_data,
  output logic                    tx_ack,
  output logic [8*DATA_BYTES-1:0] rx_data,
  output logic                    rx_valid,
  output logic                    rx_crc_err,
  output logic                    frame_err,
  output logic                    busy
);

  localparam int DATA_W = 8 * DATA_BYTES;
  localparam int FW     = DATA_W + 8;
  localparam int CW     = $clog2(FW + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_DONE} state_t;

  function automatic logic [7:0] crc8_bit(input logic [7:0] crc, input logic b);
    logic fb;
    fb = crc[7] ^ b;
    return {crc[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] crc8_word(input logic [DATA_W-1:0] d);
    logic [7:0] c;
    c = CRC_SEED;
    for (int i = DATA_W - 1; i >= 0; i--) c = crc8_bit(c, d[i]);
    return c;
  endfunction

  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   cs_prev_q, cs_prev_d;
  logic                   sclk_prev_q, sclk_prev_d;
  state_t                 state_q, state_d;
  logic [CW-1:0]          bitcnt_q, bitcnt_d;
  logic                   miso_q, miso_d;
  logic                   tx_ack_q, tx_ack_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   rx_crc_err_q, rx_crc_err_d;
  logic                   frame_err_q, frame_err_d;
  logic                   busy_q, busy_d;
  logic [DATA_W-1:0]      rx_data_q, rx_data_d;
  logic [FW-1:0]          txsr_q, txsr_d;
  logic [FW-1:0]          rxsr_q, rxsr_d;
  logic [7:0]             crc_q, crc_d;

  logic          cs_s, sclk_s, mosi_s;
  logic          cs_fall, cs_rise, sclk_rise, sclk_fall;
  logic [FW-1:0] rxsr_sh, txsr_sh;
  logic [7:0]    crc_sh;

  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign cs_fall   = cs_prev_q & ~cs_s;
  assign cs_rise   = ~cs_prev_q & cs_s;
  assign sclk_rise = ~sclk_prev_q & sclk_s;
  assign sclk_fall = sclk_prev_q & ~sclk_s;

  always_comb begin
    cs_sync_d    = {cs_sync_q[SYNC_STAGES-2:0], cs_b};
    sclk_sync_d  = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    mosi_sync_d  = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    cs_prev_d    = cs_s;
    sclk_prev_d  = sclk_s;
    state_d      = state_q;
    bitcnt_d     = bitcnt_q;
    miso_d       = miso_q;
    tx_ack_d     = 1'b0;
    rx_valid_d   = 1'b0;
    frame_err_d  = 1'b0;
    rx_data_d    = rx_data_q;
    rx_crc_err_d = rx_crc_err_q;
    txsr_d       = txsr_q;
    rxsr_d       = rxsr_q;
    crc_d        = crc_q;
    rxsr_sh      = {rxsr_q[FW-2:0], mosi_s};
    txsr_sh      = {txsr_q[FW-2:0], 1'b0};
    crc_sh       = crc8_bit(crc_q, mosi_s);

    unique case (state_q)
      ST_IDLE: begin
        miso_d = 1'b0;
        if (cs_fall) begin
          txsr_d   = {tx_data, crc8_word(tx_data)};
          miso_d   = tx_data[DATA_W-1];
          tx_ack_d = 1'b1;
          bitcnt_d = '0;
          crc_d    = CRC_SEED;
          state_d  = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        // cs_b rising has priority over any sclk edge seen in the same clock
        if (cs_rise) begin
          frame_err_d = 1'b1;
          miso_d      = 1'b0;
          state_d     = ST_IDLE;
        end else if (sclk_rise) begin
          rxsr_d   = rxsr_sh;
          crc_d    = crc_sh;
          bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q == CW'(FW - 1)) begin
            rx_data_d    = rxsr_sh[FW-1:8];
            rx_crc_err_d = (crc_sh != 8'h00);
            rx_valid_d   = 1'b1;
            miso_d       = 1'b0;
            state_d      = ST_DONE;
          end
        end else if (sclk_fall) begin
          txsr_d = txsr_sh;
          miso_d = txsr_sh[FW-1];
        end
      end
      ST_DONE: begin
        miso_d = 1'b0;
        if (cs_rise) state_d = ST_IDLE;
      end
      default: begin
        miso_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_sync_q    <= '0;
      sclk_sync_q  <= '0;
      mosi_sync_q  <= '0;
      cs_prev_q    <= 1'b0;
      sclk_prev_q  <= 1'b0;
      state_q      <= ST_IDLE;
      bitcnt_q     <= '0;
      miso_q       <= 1'b0;
      tx_ack_q     <= 1'b0;
      rx_valid_q   <= 1'b0;
      rx_crc_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
      rx_data_q    <= '0;
    end else begin
      cs_sync_q    <= cs_sync_d;
      sclk_sync_q  <= sclk_sync_d;
      mosi_sync_q  <= mosi_sync_d;
      cs_prev_q    <= cs_prev_d;
      sclk_prev_q  <= sclk_prev_d;
      state_q      <= state_d;
      bitcnt_q     <= bitcnt_d;
      miso_q       <= miso_d;
      tx_ack_q     <= tx_ack_d;
      rx_valid_q   <= rx_valid_d;
      rx_crc_err_q <= rx_crc_err_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
      rx_data_q    <= rx_data_d;
    end
  end

  // Shift registers and running CRC are always reloaded at frame start
  always_ff @(posedge clk) begin
    txsr_q <= txsr_d;
    rxsr_q <= rxsr_d;
    crc_q  <= crc_d;
  end

  assign tx_ack     = tx_ack_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign rx_crc_err = rx_crc_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
  assign miso = (cs_s || state_q == ST_IDLE) ? 1'bz : miso_q;
`else
  assign miso = miso_q;
`endif

endmodule

// File: tb/tb_spi_slave_frame.sv
// Directed bench for spi_slave_frame: bench acts as SPI master, byte-level CRC model, per-cycle output monitor.
module tb_spi_slave_frame;

  localparam int DW   = 56;
  localparam int FW   = 64;
  localparam int HALF = 6;

  logic          clk = 1'b0;
  logic          rst, cs_b, sclk, mosi;
  logic          miso, tx_ack, rx_valid, rx_crc_err, frame_err, busy;
  logic [DW-1:0] tx_data, rx_data;

  int checks = 0, failures = 0;
  int n_ack = 0, n_val = 0, n_ferr = 0, cs_hi_cnt = 0;
  logic [DW-1:0] exp_payload = '0, hold_data = '0;
  logic          exp_crc_err = 1'b0, hold_err = 1'b0;
  logic [FW-1:0] mrx;

  always #5 clk = ~clk;

  spi_slave_frame dut (
    .clk(clk), .rst(rst), .cs_b(cs_b), .sclk(sclk), .mosi(mosi), .miso(miso),
    .tx_data(tx_data), .tx_ack(tx_ack), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_crc_err(rx_crc_err), .frame_err(frame_err), .busy(busy)
  );

  // Byte-wise CRC-8 over the first nbytes of a left-aligned 64-bit stream
  function automatic logic [7:0] crc8(input logic [FW-1:0] v, input int nbytes);
    logic [7:0] c;
    c = 8'hFF;
    for (int k = 0; k < nbytes; k++) begin
      c = c ^ v[FW-1-8*k -: 8];
      for (int j = 0; j < 8; j++) c = c[7] ? ({c[6:0], 1'b0} ^ 8'h2F) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

  function automatic logic [FW-1:0] frame_of(input logic [DW-1:0] p);
    return {p, crc8({p, 8'h00}, 7)};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      hold_data = '0;
      hold_err  = 1'b0;
      cs_hi_cnt = 0;
    end else begin
      cs_hi_cnt = cs_b ? cs_hi_cnt + 1 : 0;
      if (rx_valid) begin
        n_val++;
        chk("rx_data_at_valid", rx_data, exp_payload);
        chk("rx_crc_err_at_valid", rx_crc_err, exp_crc_err);
        hold_data = exp_payload;
        hold_err  = exp_crc_err;
      end else begin
        chk("rx_data_held", rx_data, hold_data);
        chk("rx_crc_err_held", rx_crc_err, hold_err);
      end
      if (tx_ack) n_ack++;
      if (frame_err) n_ferr++;
      if (cs_hi_cnt > 6) begin
        chk("idle_miso", miso, 0);
        chk("idle_busy", busy, 0);
      end
    end
  end

  task automatic reset_mid_frame();
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_miso", miso, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_tx_ack", tx_ack, 0);
    chk("async_rst_rx_valid", rx_valid, 0);
    chk("async_rst_rx_crc_err", rx_crc_err, 0);
    chk("async_rst_frame_err", frame_err, 0);
    chk("async_rst_rx_data", rx_data, 0);
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic run_frame(input logic [DW-1:0] payload, input int nbits, input int flip,
                           input int chg_at, input logic [DW-1:0] chg_val, input int rst_at,
                           input int e_val, input int e_ferr, input int e_ack,
                           output logic [FW-1:0] rxbits);
    logic [FW-1:0] mf, sent;
    logic [DW-1:0] tx_at_start;
    int v0, f0, a0;
    mf   = frame_of(payload);
    sent = mf;
    if (flip >= 0 && flip < FW) sent[FW-1-flip] = ~sent[FW-1-flip];
    exp_payload = sent[FW-1:8];
    exp_crc_err = (crc8(sent, 8) != 8'h00);
    tx_at_start = tx_data;
    v0 = n_val; f0 = n_ferr; a0 = n_ack;
    rxbits = '0;
    @(negedge clk);
    cs_b = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) reset_mid_frame();
      if (i == chg_at) tx_data = chg_val;
      mosi = mf[FW-1-i] ^ (i == flip);
      repeat (HALF) @(negedge clk);
      rxbits = {rxbits[FW-2:0], miso};
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    cs_b = 1'b1;
    mosi = 1'b0;
    repeat (12) @(negedge clk);
    chk("rx_valid_count", n_val - v0, e_val);
    chk("frame_err_count", n_ferr - f0, e_ferr);
    chk("tx_ack_count", n_ack - a0, e_ack);
    if (nbits == FW && rst_at < 0) begin
      chk("miso_reply", rxbits, frame_of(tx_at_start));
      chk("miso_reply_residue", crc8(rxbits, 8), 0);
    end
  endtask

  initial begin
    rst = 1'b1; cs_b = 1'b1; sclk = 1'b0; mosi = 1'b0;
    tx_data = 56'hA1A2A3A4A5A6A7;
    repeat (3) @(negedge clk);
    chk("reset_miso", miso, 0);
    chk("reset_tx_ack", tx_ack, 0);
    chk("reset_rx_data", rx_data, 0);
    chk("reset_rx_valid", rx_valid, 0);
    chk("reset_rx_crc_err", rx_crc_err, 0);
    chk("reset_frame_err", frame_err, 0);
    chk("reset_busy", busy, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("model_crc8_byte00", crc8(64'h0, 1), 8'h42);

    run_frame(56'h07060504030201, 64, -1, -1, '0, -1, 1, 0, 1, mrx);
    chk("lit_reply_payload", mrx[FW-1:8], 56'hA1A2A3A4A5A6A7);
    chk("lit_rx_data", rx_data, 56'h07060504030201);
    chk("lit_rx_crc_err", rx_crc_err, 0);
    chk("busy_after_frame", busy, 0);

    run_frame(56'h07060504030201, 64, 10, -1, '0, -1, 1, 0, 1, mrx);
    chk("lit_flip_crc_err", rx_crc_err, 1);
    chk("lit_flip_rx_data", rx_data, 56'h07260504030201);

    run_frame(56'h07060504030201, 64, -1, -1, '0, -1, 1, 0, 1, mrx);
    chk("lit_clean_crc_err", rx_crc_err, 0);

    run_frame(56'h11223344556677, 56, -1, -1, '0, -1, 0, 1, 1, mrx);
    chk("lit_short_rx_data_kept", rx_data, 56'h07060504030201);

    run_frame(56'h8899AABBCCDDEE, 0, -1, -1, '0, -1, 0, 1, 1, mrx);

    run_frame(56'h11223344556677, 64, -1, -1, '0, 20, 0, 0, 1, mrx);
    chk("lit_after_rst_rx_data", rx_data, 0);

    run_frame(56'h07060504030201, 64, -1, -1, '0, -1, 1, 0, 1, mrx);
    chk("lit_recover_rx_data", rx_data, 56'h07060504030201);

    run_frame(56'h0F1E2D3C4B5A69, 64, -1, 30, 56'hB1B2B3B4B5B6B7, -1, 1, 0, 1, mrx);
    chk("lit_old_reply", mrx[FW-1:8], 56'hA1A2A3A4A5A6A7);
    run_frame(56'h0F1E2D3C4B5A69, 64, -1, -1, '0, -1, 1, 0, 1, mrx);
    chk("lit_new_reply", mrx[FW-1:8], 56'hB1B2B3B4B5B6B7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
